// File: rtl/writeback_arbiter_if.sv
// Writeback bundle: ALU/LSU result handshakes, issue-stage destination,
// register-file write port and pending-write scoreboard.
interface writeback_arbiter_if #(
   parameter int unsigned xlen = 32
) ();
   logic            alu_valid;
   logic            alu_ready;
   logic [4:0]      alu_rd;
   logic [xlen-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [xlen-1:0] lsu_data;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic            w_valid;
   logic [4:0]      w_ad;
   logic [xlen-1:0] w_data;
   logic [31:0]     busy;

   // Arbiter side
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  issue_valid, issue_rd,
      output alu_ready, lsu_ready,
      output w_valid, w_ad, w_data, busy
   );

   // Producer / register-file / issue side
   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output issue_valid, issue_rd,
      input  alu_ready, lsu_ready,
      input  w_valid, w_ad, w_data, busy
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Round-robin writeback arbiter between ALU and LSU results, driving a
// registered register-file write port and a pending-write scoreboard.
module writeback_arbiter #(
   parameter int unsigned xlen = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   writeback_arbiter_if.slave  bus
);

   typedef enum logic {
      PREF_ALU = 1'b0,
      PREF_LSU = 1'b1
   } rr_state_e;

   rr_state_e       ptr_q, ptr_d;
   logic            w_valid_q, w_valid_d;
   logic [4:0]      w_ad_q, w_ad_d;
   logic [xlen-1:0] w_data_q, w_data_d;
   logic [31:0]     busy_q, busy_d;

   logic            alu_grant;
   logic            lsu_grant;
   logic            grant;
   logic            contended;
   logic [4:0]      grant_rd;
   logic [xlen-1:0] grant_data;

   // Grant selection: single requester always wins, contention follows the pointer
   always_comb begin
      contended  = bus.alu_valid & bus.lsu_valid;
      alu_grant  = rst_n & bus.alu_valid & (~bus.lsu_valid | (ptr_q == PREF_ALU));
      lsu_grant  = rst_n & bus.lsu_valid & (~bus.alu_valid | (ptr_q == PREF_LSU));
      grant      = alu_grant | lsu_grant;
      grant_rd   = alu_grant ? bus.alu_rd   : bus.lsu_rd;
      grant_data = alu_grant ? bus.alu_data : bus.lsu_data;
   end

   // Next-state: pointer, output stage and scoreboard
   always_comb begin
      ptr_d = ptr_q;
      if (contended) begin
         ptr_d = (ptr_q == PREF_ALU) ? PREF_LSU : PREF_ALU;
      end

      // x0 results are consumed but never written; address/data hold otherwise
      w_valid_d = grant && (grant_rd != 5'd0);
      w_ad_d    = w_ad_q;
      w_data_d  = w_data_q;
      if (w_valid_d) begin
         w_ad_d   = grant_rd;
         w_data_d = grant_data;
      end

      // Set term is ORed after the clear so a same-edge re-issue stays busy
      busy_d = '0;
      for (int unsigned i = 1; i < 32; i++) begin
         busy_d[i] = (bus.issue_valid && (bus.issue_rd == 5'(i)))
                   | (busy_q[i] & ~(grant && (grant_rd == 5'(i))));
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= PREF_ALU;
         w_valid_q <= 1'b0;
         w_ad_q    <= '0;
         w_data_q  <= '0;
         busy_q    <= '0;
      end else begin
         ptr_q     <= ptr_d;
         w_valid_q <= w_valid_d;
         w_ad_q    <= w_ad_d;
         w_data_q  <= w_data_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.alu_ready = alu_grant;
   assign bus.lsu_ready = lsu_grant;
   assign bus.w_valid   = w_valid_q;
   assign bus.w_ad      = w_ad_q;
   assign bus.w_data    = w_data_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: expected writes are queued as
// stimulus is driven and compared as the write port produces them.
module tb_writeback_arbiter;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   writeback_arbiter_if #(.xlen(XLEN)) bus ();

   writeback_arbiter #(.xlen(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned n_writes = 0;
   int unsigned n_pushed = 0;
   logic [36:0] exp_q[$];

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.lsu_valid   = 1'b0;
      bus.issue_valid = 1'b0;
   endtask

   task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
      bus.alu_valid = 1'b1;
      bus.alu_rd    = rd;
      bus.alu_data  = data;
   endtask

   task automatic drive_lsu(input logic [4:0] rd, input logic [31:0] data);
      bus.lsu_valid = 1'b1;
      bus.lsu_rd    = rd;
      bus.lsu_data  = data;
   endtask

   task automatic drive_issue(input logic [4:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = rd;
   endtask

   task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
      exp_q.push_back({rd, data});
      n_pushed++;
   endtask

   // Write-port monitor: every w_valid must match the oldest queued write
   always @(posedge clk) begin
      logic [36:0] e;
      #1;
      if (rst_n === 1'b1 && bus.w_valid === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            // 0x20 is outside the 5-bit address range: no write was expected
            check_val("write_with_empty_queue", 64'(bus.w_ad), 64'h20);
         end else begin
            e = exp_q.pop_front();
            check_val("wb_ad", 64'(bus.w_ad), 64'(e[36:32]));
            check_val("wb_data", 64'(bus.w_data), 64'(e[31:0]));
         end
      end
   end

   initial begin
      logic [31:0] d;
      int unsigned ai;
      int unsigned li;
      bit exp_alu;

      rst_n        = 1'b0;
      bus.alu_rd   = '0;
      bus.alu_data = '0;
      bus.lsu_rd   = '0;
      bus.lsu_data = '0;
      bus.issue_rd = '0;
      idle();
      bus.alu_valid = 1'b1;
      bus.lsu_valid = 1'b1;
      #1;
      check_val("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      check_val("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      check_val("rst_w_valid", 64'(bus.w_valid), 64'd0);
      check_val("rst_w_ad", 64'(bus.w_ad), 64'd0);
      check_val("rst_w_data", 64'(bus.w_data), 64'd0);
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      // Mid-stream asynchronous reset
      @(negedge clk);
      drive_alu(5'd10, 32'h0000_0077);
      drive_issue(5'd12);
      push_exp(5'd10, 32'h0000_0077);
      @(posedge clk); #1;
      check_val("pre_rst_w_valid", 64'(bus.w_valid), 64'd1);
      check_val("pre_rst_busy", 64'(bus.busy), 64'h0000_1000);
      #1 rst_n = 1'b0;
      #1;
      check_val("async_rst_w_valid", 64'(bus.w_valid), 64'd0);
      check_val("async_rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      idle();
      @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      drive_alu(5'd3, 32'h0000_00A5);
      push_exp(5'd3, 32'h0000_00A5);
      #1 check_val("first_alu_ready", 64'(bus.alu_ready), 64'd1);
      @(posedge clk); #1;
      check_val("first_w_valid", 64'(bus.w_valid), 64'd1);
      check_val("first_w_ad", 64'(bus.w_ad), 64'd3);
      check_val("first_w_data", 64'(bus.w_data), 64'h00A5);

      // Contention: ALU rd 1..4 vs LSU rd 5..8, grants alternate from ALU
      ai = 0;
      li = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         idle();
         if (ai < 4) drive_alu(5'(1 + ai), 32'hA000_0000 | (1 + ai));
         if (li < 4) drive_lsu(5'(5 + li), 32'hB000_0000 | (5 + li));
         exp_alu = ((i % 2) == 0);
         #1;
         check_val("cont_alu_ready", 64'(bus.alu_ready), 64'(exp_alu));
         check_val("cont_lsu_ready", 64'(bus.lsu_ready), 64'(!exp_alu));
         if (exp_alu) begin
            push_exp(5'(1 + ai), 32'hA000_0000 | (1 + ai));
            ai++;
         end else begin
            push_exp(5'(5 + li), 32'hB000_0000 | (5 + li));
            li++;
         end
      end

      // Back-pressure: pointer now prefers LSU; one contended LSU win flips it to ALU
      @(negedge clk);
      idle();
      drive_alu(5'd13, 32'h0000_0D0D);
      drive_lsu(5'd14, 32'h0000_0E0E);
      #1;
      check_val("bp0_lsu_ready", 64'(bus.lsu_ready), 64'd1);
      check_val("bp0_alu_ready", 64'(bus.alu_ready), 64'd0);
      push_exp(5'd14, 32'h0000_0E0E);
      @(negedge clk);
      idle();
      drive_alu(5'd11, 32'h0000_0B0B);
      drive_lsu(5'd9, 32'h0000_1234);
      #1;
      check_val("bp1_alu_ready", 64'(bus.alu_ready), 64'd1);
      check_val("bp1_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      push_exp(5'd11, 32'h0000_0B0B);
      @(negedge clk);
      idle();
      drive_lsu(5'd9, 32'h0000_1234);
      #1;
      check_val("bp2_lsu_ready", 64'(bus.lsu_ready), 64'd1);
      push_exp(5'd9, 32'h0000_1234);
      @(posedge clk); #1;
      check_val("bp_w_ad", 64'(bus.w_ad), 64'd9);
      check_val("bp_w_data", 64'(bus.w_data), 64'h1234);

      // x0 destination: consumed, never written
      @(negedge clk);
      idle();
      drive_alu(5'd0, 32'hFFFF_FFFF);
      #1 check_val("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
      @(posedge clk); #1;
      check_val("x0_w_valid", 64'(bus.w_valid), 64'd0);
      check_val("x0_busy", 64'(bus.busy), 64'd0);

      // Scoreboard set / clear / set-wins / simultaneous / x0 issue
      @(negedge clk);
      idle();
      drive_issue(5'd7);
      @(posedge clk); #1;
      check_val("sb_set7", 64'(bus.busy), 64'h80);
      @(negedge clk);
      idle();
      drive_alu(5'd7, 32'h0000_0077);
      push_exp(5'd7, 32'h0000_0077);
      @(posedge clk); #1;
      check_val("sb_clr7", 64'(bus.busy), 64'd0);
      check_val("sb_clr7_w_valid", 64'(bus.w_valid), 64'd1);
      @(negedge clk);
      idle();
      drive_issue(5'd7);
      drive_lsu(5'd7, 32'h0000_0070);
      push_exp(5'd7, 32'h0000_0070);
      @(posedge clk); #1;
      check_val("sb_set_wins", 64'(bus.busy), 64'h80);
      @(negedge clk);
      idle();
      drive_issue(5'd20);
      drive_alu(5'd7, 32'h0000_0071);
      push_exp(5'd7, 32'h0000_0071);
      @(posedge clk); #1;
      check_val("sb_simul", 64'(bus.busy), 64'h0010_0000);
      @(negedge clk);
      idle();
      drive_issue(5'd0);
      @(posedge clk); #1;
      check_val("sb_issue_x0", 64'(bus.busy), 64'h0010_0000);
      check_val("sb_issue_x0_w_valid", 64'(bus.w_valid), 64'd0);

      // Throughput: alternating single-source transfers, one write every cycle
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         idle();
         d = $urandom;
         if ((i % 2) == 0) drive_alu(5'(i + 1), d);
         else              drive_lsu(5'(i + 1), d);
         push_exp(5'(i + 1), d);
         @(posedge clk); #1;
         check_val("tput_w_valid", 64'(bus.w_valid), 64'd1);
      end

      @(negedge clk);
      idle();
      repeat (3) @(posedge clk);
      #2;
      check_val("queue_drained", 64'(exp_q.size()), 64'd0);
      check_val("write_count", 64'(n_writes), 64'(n_pushed));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
